// File: rtl/dist_batch_ctrl.sv
// Streams each reference vector against the query, emits one distance per vector and tracks the batch minimum.
// First DIST_VALID VECWIDTH+1 cycles after START; a stalled DIST_READY holds the result and freezes addresses.
module dist_batch_ctrl #(
    parameter int VARWIDTH = 32,
    parameter int VECWIDTH = 10,
    parameter int NUMVEC   = 16,
    parameter int ACCWIDTH = 2*VARWIDTH + $clog2(VECWIDTH) + 1,
    localparam int QAW = (VECWIDTH > 1) ? $clog2(VECWIDTH) : 1,
    localparam int IW  = (NUMVEC > 1) ? $clog2(NUMVEC) : 1,
    localparam int RAW = (NUMVEC*VECWIDTH > 1) ? $clog2(NUMVEC*VECWIDTH) : 1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                START,
    input  logic                MODE,
    output logic [QAW-1:0]      QRY_ADDR,
    input  logic [VARWIDTH-1:0] QRY_DATA,
    output logic [RAW-1:0]      REF_ADDR,
    input  logic [VARWIDTH-1:0] REF_DATA,
    output logic [ACCWIDTH-1:0] DIST,
    output logic [IW-1:0]       DIST_IDX,
    output logic                DIST_VALID,
    input  logic                DIST_READY,
    output logic [ACCWIDTH-1:0] MIN_DIST,
    output logic [IW-1:0]       MIN_IDX,
    output logic                BUSY,
    output logic                DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [QAW-1:0] ELEM_LAST = QAW'(VECWIDTH - 1);
    localparam logic [IW-1:0]  VEC_LAST  = IW'(NUMVEC - 1);
    localparam logic [RAW-1:0] VW_R      = RAW'(VECWIDTH);

    logic [2:0]          state_q, state_d;
    logic [IW-1:0]       vec_q, vec_d;
    logic [QAW-1:0]      elem_q, elem_d;
    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic                mode_q, mode_d;
    logic [ACCWIDTH-1:0] min_dist_q, min_dist_d;
    logic [IW-1:0]       min_idx_q, min_idx_d;

    logic [VARWIDTH-1:0]   diff;
    logic [2*VARWIDTH-1:0] sq;
    logic [ACCWIDTH-1:0]   term;
    logic                  acc_en;

    assign diff = (QRY_DATA >= REF_DATA) ? (QRY_DATA - REF_DATA) : (REF_DATA - QRY_DATA);
    assign sq   = {{VARWIDTH{1'b0}}, diff} * {{VARWIDTH{1'b0}}, diff};
    assign term = mode_q ? ACCWIDTH'(diff) : ACCWIDTH'(sq);

    // Memory data lags the address by one cycle, so the first FETCH cycle of a vector has nothing to add yet.
    assign acc_en = ((state_q == S_FETCH) && (elem_q != '0)) || (state_q == S_DRAIN);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        elem_d     = elem_q;
        acc_d      = acc_q;
        mode_d     = mode_q;
        min_dist_d = min_dist_q;
        min_idx_d  = min_idx_q;
        if (acc_en) begin
            acc_d = acc_q + term;
        end
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_FETCH;
                    mode_d     = MODE;
                    vec_d      = '0;
                    elem_d     = '0;
                    acc_d      = '0;
                    min_dist_d = '1;
                    min_idx_d  = '0;
                end
            end
            S_FETCH: begin
                if (elem_q == ELEM_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    elem_d = elem_q + QAW'(1);
                end
            end
            S_DRAIN: state_d = S_EMIT;
            S_EMIT: begin
                if (DIST_READY) begin
                    // Strict compare so an equal later distance keeps the lower index.
                    if (acc_q < min_dist_q) begin
                        min_dist_d = acc_q;
                        min_idx_d  = vec_q;
                    end
                    if (vec_q != VEC_LAST) begin
                        vec_d   = vec_q + IW'(1);
                        elem_d  = '0;
                        acc_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            elem_q     <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            min_dist_q <= '0;
            min_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            elem_q     <= elem_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            min_dist_q <= min_dist_d;
            min_idx_q  <= min_idx_d;
        end
    end

    // elem stops at the last element, so addresses stay frozen through DRAIN and a stalled EMIT.
    assign QRY_ADDR   = elem_q;
    assign REF_ADDR   = RAW'(vec_q) * VW_R + RAW'(elem_q);
    assign DIST       = acc_q;
    assign DIST_IDX   = vec_q;
    assign DIST_VALID = (state_q == S_EMIT);
    assign MIN_DIST   = min_dist_q;
    assign MIN_IDX    = min_idx_q;
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = (state_q == S_FINISH);

endmodule

// File: doc/dist_batch_ctrl.md
DIST_BATCH_CTRL -- requirements
Module: dist_batch_ctrl

Interface
REQ-001 Parameter VARWIDTH, default 32: element width in bits, unsigned.
REQ-002 Parameter VECWIDTH, default 10: elements per vector, at least 1.
REQ-003 Parameter NUMVEC, default 16: reference vectors per batch, at least 1.
REQ-004 Parameter ACCWIDTH, default 2*VARWIDTH+$clog2(VECWIDTH)+1: distance/accumulator width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 START  in  1  batch start request; sampled in IDLE only.
REQ-008 MODE  in  1  distance mode, 0 = squared Euclidean, 1 = Manhattan; sampled with START.
REQ-009 QRY_ADDR  out  $clog2(VECWIDTH)  query-memory element address.
REQ-010 QRY_DATA  in  VARWIDTH  query element; valid one cycle after its QRY_ADDR.
REQ-011 REF_ADDR  out  $clog2(NUMVEC*VECWIDTH)  reference-memory address, computed as vec*VECWIDTH+elem.
REQ-012 REF_DATA  in  VARWIDTH  reference element; valid one cycle after its REF_ADDR.
REQ-013 DIST  out  ACCWIDTH  distance of the current vector.
REQ-014 DIST_IDX  out  $clog2(NUMVEC)  index of the vector that DIST belongs to.
REQ-015 DIST_VALID  out  1  DIST/DIST_IDX valid.
REQ-016 DIST_READY  in  1  consumer accepts DIST.
REQ-017 MIN_DIST  out  ACCWIDTH  smallest distance seen in the batch.
REQ-018 MIN_IDX  out  $clog2(NUMVEC)  index of MIN_DIST.
REQ-019 BUSY  out  1  high in any state other than IDLE.
REQ-020 DONE  out  1  one-cycle pulse when the batch completes.

Function
REQ-021 The block SHALL implement states IDLE, FETCH, DRAIN, EMIT and FINISH.
REQ-022 IDLE→FETCH on START=1; the block SHALL latch MODE, clear vec, elem and the accumulator, and set MIN_DIST to all-ones.
REQ-023 In FETCH the block SHALL drive QRY_ADDR=elem and REF_ADDR=vec*VECWIDTH+elem, incrementing elem each cycle; after elem=VECWIDTH-1 it SHALL go to DRAIN.
REQ-024 Each cycle after an address issue (FETCH cycles 2..VECWIDTH and the single DRAIN cycle), the block SHALL add d=|QRY_DATA-REF_DATA| when latched MODE=1, or d*d when MODE=0, into the accumulator without truncation.
REQ-025 DRAIN→EMIT after one cycle; in EMIT the block SHALL assert DIST_VALID with DIST=accumulator and DIST_IDX=vec.
REQ-026 DIST, DIST_IDX and DIST_VALID SHALL hold stable while DIST_VALID=1 and DIST_READY=0, with no further memory addresses issued.
REQ-027 On the EMIT handshake (DIST_VALID and DIST_READY both 1): if DIST<MIN_DIST (strict), MIN_DIST←DIST and MIN_IDX←vec; ties keep the lower index.
REQ-028 On the handshake: if vec<NUMVEC-1, then vec++, elem←0, accumulator←0, next state FETCH; otherwise next state FINISH.
REQ-029 FINISH SHALL pulse DONE for exactly one cycle, then return to IDLE; MIN_DIST and MIN_IDX hold until the next START.
REQ-030 Latency: first DIST_VALID SHALL assert VECWIDTH+1 cycles after the START edge; with DIST_READY held at 1, each vector takes VECWIDTH+2 cycles.
REQ-031 START while BUSY=1 SHALL be ignored; MODE changes after START SHALL have no effect until the next batch.
REQ-032 NUMVEC=1 SHALL produce one EMIT, then FINISH; VECWIDTH=1 SHALL skip directly from one FETCH cycle to DRAIN.

Reset
REQ-033 RST=1 SHALL asynchronously force IDLE and zero all outputs (DIST, DIST_IDX, DIST_VALID, MIN_DIST, MIN_IDX, BUSY, DONE, QRY_ADDR, REF_ADDR) and all counters and the accumulator.
REQ-034 RST asserted mid-batch SHALL abort the batch with no DONE pulse; a START after release SHALL begin a fresh batch from vec 0.

Verification
All scenarios use VARWIDTH=8, VECWIDTH=4, NUMVEC=3, with query [1,2,3,4] and refs v0=[1,2,3,4], v1=[0,0,0,0], v2=[5,5,5,5] unless stated otherwise.
REQ-035 MODE=0, DIST_READY=1 → DIST 0, 30, 30 for idx 0, 1, 2; MIN_DIST=0, MIN_IDX=0; first valid 5 cycles after START; DONE at cycle 18.
REQ-036 MODE=1 → DIST 0, 10, 10; MIN_DIST=0, MIN_IDX=0; ties at idx 1 and 2 do not replace the minimum.
REQ-037 Query [5,5,5,5], MODE=0 → DIST 16+9+4+1=30, then 100, then 0; MIN_DIST=0, MIN_IDX=2.
REQ-038 Query all 255, refs all 0, MODE=0 → DIST=260100 on every vector with no overflow; DIST_READY held low 7 cycles at idx 1 → DIST and DIST_IDX stable and REF_ADDR frozen.
REQ-039 RST pulsed during FETCH of vec 1 → all outputs 0, no DONE; START asserted during BUSY is ignored; a restart yields idx 0 first.
